// File: rtl/uart_pack_ctrl_if.sv
// Handshake and datapath bundle for uart_pack_ctrl.
// master: the sequencer; slave: UART rx/tx and the datapath.
interface uart_pack_ctrl_if #(
  parameter int DATA_BIT = 32
);
  logic [7:0]          i_rx_data;
  logic                i_rx_done_tick;
  logic                o_tx_start;
  logic [7:0]          o_tx_data;
  logic                i_tx_done_tick;
  logic [DATA_BIT-1:0] o_out_pattern;
  logic [DATA_BIT-1:0] o_freq_pattern;
  logic [7:0]          o_ctrl;
  logic                o_load;
  logic                i_done_tick;
  logic                o_err_tick;
  logic                o_busy;

  modport master (
    input  i_rx_data, i_rx_done_tick,
    input  i_tx_done_tick, i_done_tick,
    output o_tx_start, o_tx_data,
    output o_out_pattern, o_freq_pattern,
    output o_ctrl, o_load,
    output o_err_tick, o_busy
  );

  modport slave (
    output i_rx_data, i_rx_done_tick,
    output i_tx_done_tick, i_done_tick,
    input  o_tx_start, o_tx_data,
    input  o_out_pattern, o_freq_pattern,
    input  o_ctrl, o_load,
    input  o_err_tick, o_busy
  );
endinterface

// File: rtl/uart_pack_ctrl.sv
// UART pack sequencer: frames header/payload/checksum, loads the
// datapath, replies ACK/NAK. Ports: clk, rst, bus (master modport).
module uart_pack_ctrl #(
  parameter int          DATA_BIT = 32,
  parameter int          PACK_NUM = 9,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15,
  parameter int          TIMEOUT  = 100000,
  parameter int          TO_BIT   = 17
) (
  input  logic clk,
  input  logic rst,
  uart_pack_ctrl_if.master bus
);

  localparam int CW = $clog2(PACK_NUM + 1);
  localparam int SW = PACK_NUM * 8;

  typedef enum logic [2:0] {
    IDLE, RECV, CHECK, LOAD, WAIT_DONE, REPLY
  } state_t;

  state_t            state;
  logic [CW-1:0]     count;
  logic [7:0]        chk;
  logic              chk_ok;
  logic [TO_BIT-1:0] timer;
  // Bytes shift in from the top, so byte 0 lands in [7:0].
  logic [SW-1:0]     shadow;

  wire       rx   = bus.i_rx_done_tick;
  wire [7:0] data = bus.i_rx_data;

  assign bus.o_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      count              <= '0;
      chk                <= '0;
      chk_ok             <= 1'b0;
      timer              <= '0;
      shadow             <= '0;
      bus.o_tx_start     <= 1'b0;
      bus.o_tx_data      <= '0;
      bus.o_out_pattern  <= '0;
      bus.o_freq_pattern <= '0;
      bus.o_ctrl         <= '0;
      bus.o_load         <= 1'b0;
      bus.o_err_tick     <= 1'b0;
    end else begin
      bus.o_tx_start <= 1'b0;
      bus.o_load     <= 1'b0;
      bus.o_err_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rx && data == HEADER) begin
            state <= RECV;
            count <= '0;
            chk   <= '0;
            // timer holds cycles elapsed since the last tick
            timer <= TO_BIT'(1);
          end
        end
        RECV: begin
          if (rx) begin
            timer <= TO_BIT'(1);
            if (count == CW'(PACK_NUM)) begin
              chk_ok <= (data == chk);
              state  <= CHECK;
            end else begin
              shadow <= {data, shadow[SW-1:8]};
              chk    <= chk ^ data;
              count  <= count + 1'b1;
            end
          end else if (timer == TO_BIT'(TIMEOUT - 1)) begin
            bus.o_err_tick <= 1'b1;
            state          <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          if (chk_ok) begin
            bus.o_out_pattern  <= shadow[DATA_BIT-1:0];
            bus.o_freq_pattern <= shadow[2*DATA_BIT-1:DATA_BIT];
            bus.o_ctrl         <= shadow[SW-1 -: 8];
            bus.o_load         <= 1'b1;
            state              <= LOAD;
          end else begin
            bus.o_err_tick <= 1'b1;
            bus.o_tx_data  <= NAK_BYTE;
            bus.o_tx_start <= 1'b1;
            state          <= REPLY;
          end
        end
        LOAD: begin
          if (bus.o_ctrl[0]) begin
            state <= WAIT_DONE;
          end else begin
            bus.o_tx_data  <= ACK_BYTE;
            bus.o_tx_start <= 1'b1;
            state          <= REPLY;
          end
        end
        WAIT_DONE: begin
          if (bus.i_done_tick) begin
            bus.o_tx_data  <= ACK_BYTE;
            bus.o_tx_start <= 1'b1;
            state          <= REPLY;
          end
        end
        REPLY: begin
          if (bus.i_tx_done_tick) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_pack_ctrl.md
Name: uart_pack_ctrl

Overview:
Command sequencer between the UART receiver/transmitter and the diff_freq_serial_out datapath. It frames incoming UART bytes into packs: header, output pattern, frequency pattern, control byte and XOR checksum. It validates each pack, loads the datapath, optionally waits for the datapath to finish, and returns a one-byte ACK/NAK over the UART transmitter. It replaces the direct rx-to-datapath byte feed and the rx-to-tx echo loopback.

Parameters:
DATA_BIT, 32, width of the output pattern and of the frequency pattern; must be a multiple of 8
PACK_NUM, 9, payload bytes per pack = (DATA_BIT/8)*2+1
HEADER, 8'hA5, start-of-pack byte
ACK_BYTE, 8'h06, reply on success
NAK_BYTE, 8'h15, reply on checksum error
TIMEOUT, 100000, maximum clk cycles between consecutive rx ticks inside a pack
TO_BIT, 17, counter width; must satisfy 2^TO_BIT > TIMEOUT

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
i_rx_data  input  8  received byte, valid while i_rx_done_tick=1
i_rx_done_tick  input  1  one-cycle pulse per received byte
o_tx_start  output  1  one-cycle request to transmit o_tx_data
o_tx_data  output  8  reply byte, held stable from the o_tx_start cycle until i_tx_done_tick
i_tx_done_tick  input  1  transmitter finished pulse
o_out_pattern  output  DATA_BIT  output pattern register
o_freq_pattern  output  DATA_BIT  frequency pattern register
o_ctrl  output  8  control byte register; bit0=run
o_load  output  1  one-cycle pulse: pattern registers updated, datapath starts
i_done_tick  input  1  datapath finished pulse
o_err_tick  output  1  one-cycle pulse on checksum error or timeout
o_busy  output  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE. All outputs are 0, including the pattern registers and o_tx_data. The byte counter, checksum accumulator and timeout counter clear. Reset mid-pack or mid-reply abandons the pack; any tx request in flight is dropped.
- IDLE: on an rx tick with data==HEADER, go to RECV with count=0, chk=0, timer=0. Any other byte is ignored.
- RECV:
  - Payload byte k (k=0..PACK_NUM-1) goes into the shadow buffer, and chk ^= byte.
  - Byte order:
    - Bytes 0..DATA_BIT/8-1 form the output pattern, LSB byte first.
    - The next DATA_BIT/8 bytes form the frequency pattern, LSB byte first.
    - The last payload byte is the control byte.
  - Byte PACK_NUM is the checksum; it is compared against chk. No further byte is accumulated.
  - The timer resets on each rx tick and otherwise increments.
  - When timer reaches TIMEOUT: pulse o_err_tick, go to IDLE, send no reply.
- CHECK is entered the cycle after the checksum tick (cycle N+1).
  - Match: go to LOAD.
  - Mismatch: pulse o_err_tick and go to REPLY with o_tx_data=NAK_BYTE. Output registers stay unchanged.
- LOAD (cycle N+2):
  - o_load=1 for exactly one cycle.
  - o_out_pattern, o_freq_pattern and o_ctrl take the shadow values on the edge entering LOAD, so they are valid in the same cycle as o_load.
  - Next state: WAIT_DONE if ctrl bit0=1, otherwise REPLY with ACK_BYTE.
- WAIT_DONE: on i_done_tick go to REPLY with ACK_BYTE. There is no timeout in this state. An i_done_tick in any other state is ignored.
- REPLY: o_tx_start=1 on the first cycle only, then wait for i_tx_done_tick and go to IDLE.
- Rx ticks in CHECK, LOAD, WAIT_DONE and REPLY are dropped; no error is raised.
- A HEADER value received inside RECV is treated as data, not as a restart.
- Simultaneous timer expiry and rx tick: the rx tick wins and the byte is accepted.
- Pattern registers hold their values between packs.

Test Plan:
- Valid run pack: A5 11 22 33 44 55 66 77 88 01 89.
  - Expect o_load 2 cycles after the 0x89 tick, with o_out_pattern=32'h44332211, o_freq_pattern=32'h88776655, o_ctrl=8'h01.
  - No tx until i_done_tick; then o_tx_start with o_tx_data=8'h06.
- Config-only pack: same bytes with ctrl 00 and checksum 88.
  - Expect o_load, then o_tx_start/8'h06 on the cycle after LOAD without any i_done_tick.
- Bad checksum: the first pack with checksum 0x00.
  - Expect o_err_tick, o_tx_data=8'h15, no o_load, pattern registers unchanged.
- Timeout: A5 11 22 then silence.
  - Expect o_err_tick exactly TIMEOUT cycles after the 0x22 tick, return to IDLE, no tx.
  - A following valid pack is accepted normally.
- Noise and reset:
  - Bytes 00 FF before A5 are ignored.
  - Asserting rst after the 4th payload byte clears all outputs and returns to IDLE.
  - Bytes sent during WAIT_DONE are dropped and do not start a new pack.
